// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg -- shared definitions for the GF(2^8) multiplier (Kuznechik field).
//
// Field: GF(2^8) with reduction polynomial x^8+x^7+x^6+x+1 (0x1C3). Only the
// low 8 bits are stored as POLY_DEFAULT; the x^8 term is implied everywhere.
//
// Contents:
//   GF_W          field element width (8)
//   PROD_W        width of an unreduced carry-less product (15)
//   POLY_DEFAULT  low byte of the reduction polynomial (8'hC3)
//   gf_xtime      multiply a field element by x, with reduction
//   gf_clmul      15-bit carry-less product of two bytes
//   gf_reduce     reduce a 15-bit carry-less product to a field element
// ---------------------------------------------------------------------------
package gf_pkg;

  localparam int GF_W   = 8;
  localparam int PROD_W = 2 * GF_W - 1;

  localparam logic [GF_W-1:0] POLY_DEFAULT = 8'hC3;

  function automatic logic [GF_W-1:0] gf_xtime(
    input logic [GF_W-1:0] v,
    input logic [GF_W-1:0] poly = POLY_DEFAULT
  );
    return {v[GF_W-2:0], 1'b0} ^ (v[GF_W-1] ? poly : '0);
  endfunction

  function automatic logic [PROD_W-1:0] gf_clmul(
    input logic [GF_W-1:0] a,
    input logic [GF_W-1:0] b
  );
    logic [PROD_W-1:0] p;
    p = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p ^= (PROD_W'(a) << i);
    end
    return p;
  endfunction

  // Horner evaluation from the top: the upper 8 bits are already a reduced
  // element, and each remaining low bit is folded in after one xtime step.
  function automatic logic [GF_W-1:0] gf_reduce(
    input logic [PROD_W-1:0] p,
    input logic [GF_W-1:0]   poly = POLY_DEFAULT
  );
    logic [GF_W-1:0] acc;
    acc = p[PROD_W-1:GF_W-1];
    for (int k = GF_W - 2; k >= 0; k--) begin
      acc = gf_xtime(acc, poly) ^ {{(GF_W-1){1'b0}}, p[k]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_xtime_cell.sv
// ---------------------------------------------------------------------------
// gf_xtime_cell -- combinational multiply-by-x in GF(2^8).
//
// y = (v << 1) mod {1, POLY}. Used as the repeated step of the reducer chain.
//
// Ports:
//   v  in   8  field element
//   y  out  8  v * x, reduced
// ---------------------------------------------------------------------------
module gf_xtime_cell
  import gf_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic [GF_W-1:0] v,
  output logic [GF_W-1:0] y
);

  assign y = gf_xtime(v, POLY);

endmodule

// File: rtl/mult_gf.sv
// ---------------------------------------------------------------------------
// mult_gf -- GF(2^8) multiplier for the Kuznechik L-transform.
//
// c is the purely combinational product a*b mod {1,POLY}. c_q/out_valid is
// a registered copy for pipelined use: a pair qualified by in_valid appears
// on c_q with out_valid=1 one cycle later; c_q holds when nothing new
// arrives. rst_n (asynchronous, active low) empties the registered path.
//
// Optional build macro MULT_GF_PIPE2_EN: the registered path becomes two
// stages (unreduced 15-bit product, then reduced result), latency 2,
// throughput still one pair per cycle. c is unaffected.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   a, b       in   8  operands
//   in_valid   in   1  a/b qualify for the registered path this cycle
//   c          out  8  combinational product
//   c_q        out  8  registered product
//   out_valid  out  1  c_q holds a freshly produced product
// ---------------------------------------------------------------------------
module mult_gf
  import gf_pkg::*;
#(
  parameter logic [GF_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  input  logic            in_valid,
  output logic [GF_W-1:0] c,
  output logic [GF_W-1:0] c_q,
  output logic            out_valid
);

`ifdef MULT_GF_PIPE2_EN
  // Lane 0 reduces the live product for c, lane 1 the stage-1 register.
  localparam int N_RED = 2;
`else
  localparam int N_RED = 1;
`endif

  logic [PROD_W-1:0] pp [GF_W];
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] red_src [N_RED];
  logic [GF_W-1:0]   red_out [N_RED];

  logic [GF_W-1:0]   c_q_reg;
  logic              out_valid_reg;

  genvar gi, gl;

  // ---- carry-less product: one shifted copy of a per set bit of b --------
  for (gi = 0; gi < GF_W; gi++) begin : g_pp
    assign pp[gi] = b[gi] ? (PROD_W'(a) << gi) : '0;
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      prod ^= pp[i];
    end
  end

  // ---- reducer lanes: 7 chained xtime cells each -------------------------
  // Each step keeps its own signals so the chain has no self-referencing
  // vector; step gi folds in product bit (6 - gi).
  for (gl = 0; gl < N_RED; gl++) begin : g_lane
    for (gi = 0; gi < GF_W - 1; gi++) begin : g_step
      logic [GF_W-1:0] acc_in;
      logic [GF_W-1:0] shifted;
      logic [GF_W-1:0] acc_out;

      if (gi == 0) begin : g_head
        assign acc_in = red_src[gl][PROD_W-1:GF_W-1];
      end else begin : g_link
        assign acc_in = g_step[gi-1].acc_out;
      end

      gf_xtime_cell #(.POLY(POLY)) u_xtime (
        .v (acc_in),
        .y (shifted)
      );

      assign acc_out = shifted ^ {{(GF_W-1){1'b0}}, red_src[gl][GF_W-2-gi]};
    end

    assign red_out[gl] = g_step[GF_W-2].acc_out;
  end

  assign red_src[0] = prod;
  assign c          = red_out[0];

`ifdef MULT_GF_PIPE2_EN
  // ---- two-stage registered path -----------------------------------------
  logic [PROD_W-1:0] prod_q_reg;
  logic              s1_valid_reg;

  assign red_src[1] = prod_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      c_q_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg  <= in_valid;
      out_valid_reg <= s1_valid_reg;
      if (in_valid)     prod_q_reg <= prod;
      if (s1_valid_reg) c_q_reg    <= red_out[1];
    end
  end
`else
  // ---- single-stage registered path --------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) c_q_reg <= red_out[0];
    end
  end
`endif

  assign c_q       = c_q_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mult_gf.sv
// ---------------------------------------------------------------------------
// tb_mult_gf -- self-checking bench for mult_gf.
//
// Reference model: Russian-peasant GF(2^8) multiply on plain integers with
// the full 0x1C3 polynomial. The registered path is predicted from a history
// of accepted inputs: after n edges since reset, out_valid is the in_valid
// seen LAT edges back and c_q is the product of the latest valid pair at or
// before that point. Honours MULT_GF_PIPE2_EN (latency 2).
// ---------------------------------------------------------------------------
module tb_mult_gf;
  import gf_pkg::*;

`ifdef MULT_GF_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } vec_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a        = 8'h00;
  logic [7:0] b        = 8'h00;
  logic [7:0] c;
  logic [7:0] c_q;
  logic       out_valid;

  int n_vec = 0;
  int n_err = 0;

  logic       hv [$];
  logic [7:0] hp [$];

  mult_gf #(.POLY(8'hC3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .c         (c),
    .c_q       (c_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_model(input logic [7:0] x, input logic [7:0] y);
    int aa = int'(x);
    int bb = int'(y);
    int r  = 0;
    while (bb != 0) begin
      if ((bb & 1) != 0) r ^= aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa ^= 'h1C3;
      bb = bb >> 1;
    end
    return r[7:0];
  endfunction

  // Input history since the last reset, one entry per rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv.delete();
      hp.delete();
    end else begin
      hv.push_back(in_valid);
      hp.push_back(gf_model(a, b));
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h (a=%02h b=%02h)", name, act, exp, a, b);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name);
    int         n  = hv.size();
    logic       ev = 1'b0;
    logic [7:0] ed = 8'h00;
    if (n >= LAT) begin
      ev = hv[n-LAT];
      for (int j = n - LAT; j >= 0; j--) begin
        if (hv[j]) begin
          ed = hp[j];
          break;
        end
      end
    end
    check1({name, "_ov"}, out_valid, ev);
    check8({name, "_cq"}, c_q, ed);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       kv [11];
    logic [7:0] rs_a [3];
    logic [7:0] rs_b [3];
    logic [7:0] rs_p [3];
    int         j;

    kv[0]  = '{a: 8'h57, b: 8'h83, p: 8'hF2};
    kv[1]  = '{a: 8'hAB, b: 8'hC4, p: 8'hB2};
    kv[2]  = '{a: 8'hFF, b: 8'hFF, p: 8'h06};
    kv[3]  = '{a: 8'h80, b: 8'h80, p: 8'h77};
    kv[4]  = '{a: 8'h10, b: 8'h20, p: 8'h45};
    kv[5]  = '{a: 8'h1D, b: 8'hE3, p: 8'hD5};
    kv[6]  = '{a: 8'hC0, b: 8'hD1, p: 8'h87};
    kv[7]  = '{a: 8'h00, b: 8'h00, p: 8'h00};
    kv[8]  = '{a: 8'h01, b: 8'h01, p: 8'h01};
    kv[9]  = '{a: 8'h22, b: 8'h11, p: 8'h47};
    kv[10] = '{a: 8'h11, b: 8'h22, p: 8'h47};

    rs_a[0] = 8'h57; rs_b[0] = 8'h83; rs_p[0] = 8'hF2;
    rs_a[1] = 8'hAA; rs_b[1] = 8'h55; rs_p[1] = 8'hBD;
    rs_a[2] = 8'h77; rs_b[2] = 8'h88; rs_p[2] = 8'h58;

    // ---- reset state -----------------------------------------------------
    #17;
    check8("rst_cq", c_q, 8'h00);
    check1("rst_ov", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- known products on c ---------------------------------------------
    for (int i = 0; i < 11; i++) begin
      a = kv[i].a;
      b = kv[i].b;
      #10;
      $display("known %02h*%02h -> c=%02h (want %02h)", kv[i].a, kv[i].b, c, kv[i].p);
      check8($sformatf("known_%02hx%02h", kv[i].a, kv[i].b), c, kv[i].p);
    end

    // ---- identities over all a -------------------------------------------
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      b = 8'h01;
      #1;
      check8("id_mul1", c, 8'(i));
      b = 8'h00;
      #1;
      check8("id_mul0", c, 8'h00);
    end
    $display("identities a*01, a*00 applied for 256 values of a");

    // ---- exhaustive sweep on c -------------------------------------------
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] ab;
      logic [7:0]  e;
      ab = 16'(i);
      a  = ab[15:8];
      b  = ab[7:0];
      e  = gf_model(a, b);
      #1;
      check8("sweep_c", c, e);
      check8("sweep_pkg", gf_reduce(gf_clmul(a, b)), e);
    end
    $display("exhaustive sweep of 65536 pairs applied");

    // ---- registered path: three back-to-back pairs -----------------------
    @(negedge clk);
    a = rs_a[0]; b = rs_b[0]; in_valid = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        a = rs_a[k]; b = rs_b[k];
      end else begin
        in_valid = 1'b0;
      end
      j = k - LAT;
      $display("reg cycle %0d: c_q=%02h out_valid=%0b", k, c_q, out_valid);
      if (j < 0) begin
        check1("seq_pre_ov", out_valid, 1'b0);
      end else if (j <= 2) begin
        check1($sformatf("seq%0d_ov", j), out_valid, 1'b1);
        check8($sformatf("seq%0d_cq", j), c_q, rs_p[j]);
      end else begin
        check1("seq_drop_ov", out_valid, 1'b0);
        check8("seq_hold_cq", c_q, 8'h58);
      end
    end

    // ---- reset mid-stream --------------------------------------------------
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_reg("pre_rst");
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    end
    @(negedge clk);
    check1("pre_rst_busy_ov", out_valid, 1'b1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check8("midrst_cq", c_q, 8'h00);
    check1("midrst_ov", out_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check8("empty_cq", c_q, 8'h00);
      check1("empty_ov", out_valid, 1'b0);
    end
    a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    $display("post-reset A5*5A -> c_q=%02h out_valid=%0b", c_q, out_valid);
    check8("post_rst_cq", c_q, 8'hA4);
    check1("post_rst_ov", out_valid, 1'b1);
    @(negedge clk);
    check8("post_rst_hold_cq", c_q, 8'hA4);
    check1("post_rst_drop_ov", out_valid, 1'b0);

    // ---- random traffic on both paths --------------------------------------
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      check_reg("rand");
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = ($urandom_range(3, 0) != 0);
      #1;
      check8("rand_c", c, gf_model(a, b));
    end
    in_valid = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      check_reg("drain");
    end
    $display("random traffic: 400 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_gf.md
Name: mult_gf

Overview:
- GF(2^8) multiplier for the Kuznechik datapath (L-transform linear layer).
- Reduction polynomial: x^8+x^7+x^6+x+1 (0x1C3).
- Provides a combinational product output and a registered, valid-tagged product output for pipelined use.
- The combinational path must match a pure-function multiplier bit-exactly.

Parameters:
- POLY, 8'hC3, low 8 bits of the reduction polynomial; x^8 term implied. Default gives 0x1C3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  8  multiplicand.
- b  input  8  multiplier.
- in_valid  input  1  a/b qualify for the registered path this cycle.
- c  output  8  combinational product a*b mod POLY.
- c_q  output  8  registered product.
- out_valid  output  1  c_q holds a valid product.

Behaviour:
- Arithmetic:
  - c = carry-less product of a and b (15-bit, bits 14..0), reduced modulo {1,POLY}.
  - Equivalent shift-and-add form: for i = 7 down to 0, acc = xtime(acc) ^ (b[i] ? a : 0).
  - xtime(v) = (v<<1)[7:0] ^ (v[7] ? POLY : 0).
- c is purely combinational from a and b. It is independent of clk, rst_n and in_valid, and settles within one delta/propagation window.
- Identities that must hold:
  - a*0 = 0.
  - a*1 = a.
  - Commutative: a*b = b*a.
  - Distributive over XOR.
- Registered path, default latency 1:
  - On a rising edge with in_valid=1: c_q <= a*b, out_valid <= 1.
  - On a rising edge with in_valid=0: c_q holds its value, out_valid <= 0.
- Back-to-back operation: one new operand pair is accepted every cycle; no stalls, no backpressure.
- Reset:
  - rst_n low asynchronously forces c_q=8'h00 and out_valid=0 at any time, including mid-operation. Any in-flight product is discarded.
  - On the first edge after rst_n rises, in_valid is sampled normally.
- No X propagation from the registered path out of reset; c_q and out_valid are always defined.

Optional Feature:
- Macro: MULT_GF_PIPE2_EN.
- Defined (2-stage pipeline):
  - Stage 1 registers the 15-bit unreduced carry-less product and a valid bit.
  - Stage 2 registers the reduced result into c_q and sets out_valid.
  - Latency is 2 cycles; throughput stays 1 per cycle.
  - Reset clears both stages.
  - c is unchanged, still combinational.
- Undefined: latency-1 behaviour as above.

Decomposition:
- Package gf_pkg holds:
  - GF_W = 8 and the POLY default 8'hC3.
  - Function gf_xtime(byte).
  - Function gf_clmul(a, b), returning 15 bits.
  - Function gf_reduce(15-bit), returning 8 bits.
- Natural sub-module: gf_xtime_cell, the combinational multiply-by-x with reduction. It is chained 7 times in the reducer; stage boundaries reuse it.

Test Plan:
- Known products on c, checked after 10 ns settle:
  - 57*83 -> F2
  - AB*C4 -> B2
  - FF*FF -> 06
  - 80*80 -> 77
  - 10*20 -> 45
  - 1D*E3 -> D5
  - C0*D1 -> 87
- Identities:
  - 00*00 -> 00
  - 01*01 -> 01
  - a*01 -> a, and a*00 -> 00, for all 256 values of a
  - 22*11 -> 47 and 11*22 -> 47 (commutativity)
- Registered path:
  - Assert in_valid for 3 consecutive cycles with pairs (57,83), (AA,55), (77,88).
  - c_q must show F2, BD, 58 on consecutive cycles with out_valid=1, starting 1 cycle later (2 cycles with MULT_GF_PIPE2_EN).
  - out_valid must drop the cycle after in_valid drops.
- Reset mid-stream:
  - Pulse rst_n low asynchronously, between edges, while out_valid=1.
  - c_q=00 and out_valid=0 immediately.
  - The pipeline is empty after release.
  - The next accepted pair (A5,5A) yields A4.
- Exhaustive sweep: all 65536 (a,b) pairs on c checked against the gf_pkg reference function; random pairs on c_q checked against a scoreboard delayed by the configured latency.
